// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, default bit timing and
// frame constants used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START_BIT = 2'd1,
        ST_DATA_BITS = 2'd2,
        ST_STOP_BIT  = 2'd3
    } tx_state_t;

    // 50 MHz / 9600 baud
    localparam int   DEFAULT_CLKS_PER_BIT = 5208;
    localparam int   DATA_BITS            = 8;
    localparam logic IDLE_LEVEL           = 1'b1;

    // Width of a counter holding 0..clks-1 (at least one bit).
    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period. A clear restarts the period at zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_r;

    // Period counter: clear wins, otherwise wrap at the end of each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    // Decoded from the counter register; independent of clear so the final
    // edge of a bit can itself restart the counter for the next frame.
    assign bit_end = enable && (count_r == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with a one-byte holding register so that frames can
// be sent back-to-back. Line is driven LSB first; every output is registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DATA,
    input  logic       START,
    output logic       READY,
    output logic       TX_LINE,
    output logic       BUSY,
    output logic       DONE
);

    tx_state_t  state_r, state_s;
    logic [7:0] shift_r, shift_s;
    logic [7:0] hold_r, hold_s;
    logic       hold_full_r, hold_full_s;
    logic [2:0] bit_idx_r, bit_idx_s;
    logic       stop_idx_r, stop_idx_s;
    logic       load_s;
    logic       done_s;
    logic       tx_s;
    logic       bit_end_s;
    logic       stop_last_s;
    logic       ready_r, tx_line_r, busy_r, done_r;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (load_s),
        .enable  (state_r != ST_IDLE),
        .bit_end (bit_end_s)
    );

    assign stop_last_s = (stop_idx_r == 1'(STOP_BITS - 1));

    // Next-state, datapath and holding-register control.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        bit_idx_s   = bit_idx_r;
        stop_idx_s  = stop_idx_r;
        load_s      = 1'b0;
        done_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (hold_full_r) begin
                    load_s  = 1'b1;
                    state_s = ST_START_BIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START_BIT: begin
                if (bit_end_s) begin
                    state_s   = ST_DATA_BITS;
                    bit_idx_s = 3'd0;
                end else begin
                    state_s = ST_START_BIT;
                end
            end
            ST_DATA_BITS: begin
                if (bit_end_s) begin
                    if (bit_idx_r == 3'(DATA_BITS - 1)) begin
                        state_s    = ST_STOP_BIT;
                        stop_idx_s = 1'b0;
                    end else begin
                        shift_s   = {1'b0, shift_r[7:1]};
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_s = ST_DATA_BITS;
                end
            end
            ST_STOP_BIT: begin
                if (bit_end_s) begin
                    if (stop_last_s) begin
                        done_s = 1'b1;
                        if (hold_full_r) begin
                            load_s  = 1'b1;
                            state_s = ST_START_BIT;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        stop_idx_s = stop_idx_r + 1'b1;
                    end
                end else begin
                    state_s = ST_STOP_BIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Moving the held byte into the shifter frees the holding register.
        if (load_s) begin
            shift_s     = hold_r;
            hold_full_s = 1'b0;
        end else begin
            hold_full_s = hold_full_s;
        end

        // READY is registered from "holding empty", so an accept can never
        // coincide with a load of an unsent byte.
        if (START && ready_r) begin
            hold_s      = DATA;
            hold_full_s = 1'b1;
        end else begin
            hold_s = hold_s;
        end
    end

    // Line level follows the state being entered so TX_LINE can be registered.
    always_comb begin
        tx_s = IDLE_LEVEL;
        case (state_s)
            ST_IDLE:      tx_s = IDLE_LEVEL;
            ST_START_BIT: tx_s = ~IDLE_LEVEL;
            ST_DATA_BITS: tx_s = shift_s[0];
            ST_STOP_BIT:  tx_s = IDLE_LEVEL;
            default:      tx_s = IDLE_LEVEL;
        endcase
    end

    // State, datapath and registered outputs; reset forces the line idle at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            shift_r     <= 8'h00;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            bit_idx_r   <= 3'd0;
            stop_idx_r  <= 1'b0;
            ready_r     <= 1'b1;
            tx_line_r   <= IDLE_LEVEL;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            bit_idx_r   <= bit_idx_s;
            stop_idx_r  <= stop_idx_s;
            ready_r     <= ~hold_full_s;
            tx_line_r   <= tx_s;
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= done_s;
        end
    end

    assign READY   = ready_r;
    assign TX_LINE = tx_line_r;
    assign BUSY    = busy_r;
    assign DONE    = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Three instances cover 16 clk/bit with one
// and two stop bits and the default 5208 clk/bit timing. Expected line levels
// come from the frame rule: start 0, eight data bits LSB first, stop bits 1.
module tb_uart_tx;

    typedef logic [7:0] bytes_t [8];

    logic       clk = 1'b0;
    logic       rst_n   [3];
    logic [7:0] data    [3];
    logic       start   [3];
    logic       ready_s [3];
    logic       tx_s    [3];
    logic       busy_s  [3];
    logic       done_s  [3];

    int n_cmp  = 0;
    int n_fail = 0;

    initial forever #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(1)) dut0 (
        .CLK(clk), .RST_N(rst_n[0]), .DATA(data[0]), .START(start[0]),
        .READY(ready_s[0]), .TX_LINE(tx_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0]));

    uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2)) dut1 (
        .CLK(clk), .RST_N(rst_n[1]), .DATA(data[1]), .START(start[1]),
        .READY(ready_s[1]), .TX_LINE(tx_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1]));

    uart_tx #(.CLKS_PER_BIT(5208), .STOP_BITS(1)) dut2 (
        .CLK(clk), .RST_N(rst_n[2]), .DATA(data[2]), .START(start[2]),
        .READY(ready_s[2]), .TX_LINE(tx_s[2]), .BUSY(busy_s[2]), .DONE(done_s[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int sel, input string name);
        int t = 0;
        while (ready_s[sel] !== 1'b1 && t < 2000) begin
            step();
            t++;
        end
        if (ready_s[sel] !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_ready_timeout: READY=%b, want 1", name, ready_s[sel]);
        end
    endtask

    // Present a byte and hold START for exactly one accepting edge.
    task automatic send(input int sel, input logic [7:0] b, input string name);
        wait_ready(sel, name);
        data[sel]  = b;
        start[sel] = 1'b1;
        step();
        start[sel] = 1'b0;
        data[sel]  = 8'($urandom);
    endtask

    // Called just after the edge where the first start bit appears; checks n
    // contiguous frames cycle by cycle, decodes each mid-bit, then the idle tail.
    task automatic check_stream(input int sel, input bytes_t bytes, input int n,
                                input int c, input int s, input string name);
        int l, f, j, bi, lvl_err, busy_err, done_err, first_bad;
        logic exp_lvl;
        logic exp_done;
        logic [7:0] dec [8];
        l = (9 + s) * c;
        lvl_err = 0; busy_err = 0; done_err = 0; first_bad = -1;
        for (int k = 0; k < n * l; k++) begin
            f  = k / l;
            j  = k % l;
            bi = j / c;
            if (bi == 0)      exp_lvl = 1'b0;
            else if (bi <= 8) exp_lvl = bytes[f][bi-1];
            else              exp_lvl = 1'b1;
            exp_done = (j == 0 && k > 0);
            if (tx_s[sel] !== exp_lvl) begin
                if (lvl_err == 0) first_bad = k;
                lvl_err++;
            end
            if (busy_s[sel] !== 1'b1) busy_err++;
            if (done_s[sel] !== exp_done) done_err++;
            if (bi >= 1 && bi <= 8 && (j % c) == c / 2) dec[f][bi-1] = tx_s[sel];
            step();
        end
        n_cmp++;
        if (lvl_err != 0) begin
            n_fail++;
            $display("FAIL %s_levels: %0d wrong cycles (first at cycle %0d), want 0", name, lvl_err, first_bad);
        end
        n_cmp++;
        if (busy_err != 0) begin
            n_fail++;
            $display("FAIL %s_busy: BUSY low on %0d frame cycles, want 0", name, busy_err);
        end
        n_cmp++;
        if (done_err != 0) begin
            n_fail++;
            $display("FAIL %s_done_inframe: %0d wrong DONE cycles, want 0", name, done_err);
        end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (dec[i] !== bytes[i]) begin
                n_fail++;
                $display("FAIL %s_decode[%0d]: got %h want %h", name, i, dec[i], bytes[i]);
            end
        end
        n_cmp++;
        if ({done_s[sel], busy_s[sel], tx_s[sel]} !== 3'b101) begin
            n_fail++;
            $display("FAIL %s_end: DONE,BUSY,TX=%b%b%b want 101", name, done_s[sel], busy_s[sel], tx_s[sel]);
        end
        step();
        n_cmp++;
        if ({done_s[sel], busy_s[sel], tx_s[sel], ready_s[sel]} !== 4'b0011) begin
            n_fail++;
            $display("FAIL %s_after: DONE,BUSY,TX,READY=%b%b%b%b want 0011", name,
                     done_s[sel], busy_s[sel], tx_s[sel], ready_s[sel]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            start[i] = 1'b0;
            data[i]  = 8'h00;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({ready_s[i], tx_s[i], busy_s[i], done_s[i]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_dut%0d: READY,TX,BUSY,DONE=%b%b%b%b want 1100", i,
                         ready_s[i], tx_s[i], busy_s[i], done_s[i]);
            end
            rst_n[i] = 1'b1;
        end
        step();
        step();
    endtask

    task automatic test_single();
        bytes_t b;
        b[0] = 8'h55;
        send(0, b[0], "single");
        n_cmp++;
        if ({ready_s[0], tx_s[0], busy_s[0]} !== 3'b010) begin
            n_fail++;
            $display("FAIL single_accept: READY,TX,BUSY=%b%b%b want 010", ready_s[0], tx_s[0], busy_s[0]);
        end
        step();
        check_stream(0, b, 1, 16, 1, "single");
    endtask

    task automatic test_back_to_back();
        bytes_t b;
        b[0] = 8'hA5;
        b[1] = 8'h3C;
        send(0, b[0], "b2b");
        step();
        fork
            check_stream(0, b, 2, 16, 1, "b2b");
            send(0, b[1], "b2b");
        join
    endtask

    task automatic test_ignored();
        bytes_t b;
        int idle_err;
        b[0] = 8'h11;
        b[1] = 8'h12;
        send(0, b[0], "ignored");
        step();
        fork
            check_stream(0, b, 2, 16, 1, "ignored");
            begin
                send(0, b[1], "ignored");
                data[0]  = 8'hFF;
                start[0] = 1'b1;
                for (int t = 0; t < 1000; t++) begin
                    step();
                    if (ready_s[0] === 1'b1) break;
                end
                start[0] = 1'b0;
            end
        join
        idle_err = 0;
        for (int t = 0; t < 40; t++) begin
            if (busy_s[0] !== 1'b0 || tx_s[0] !== 1'b1) idle_err++;
            step();
        end
        n_cmp++;
        if (idle_err != 0) begin
            n_fail++;
            $display("FAIL ignored_idle: %0d non-idle cycles after frames, want 0", idle_err);
        end
    endtask

    task automatic test_reset_mid();
        bytes_t b;
        send(0, 8'hF0, "rstmid");
        step();
        repeat (16 + 3 * 16 + 8) step();
        n_cmp++;
        if (tx_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_bit3: TX=%b want 0", tx_s[0]);
        end
        #2;
        rst_n[0] = 1'b0;
        #1;
        n_cmp++;
        if ({ready_s[0], tx_s[0], busy_s[0], done_s[0]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL rstmid_async: READY,TX,BUSY,DONE=%b%b%b%b want 1100",
                     ready_s[0], tx_s[0], busy_s[0], done_s[0]);
        end
        step();
        rst_n[0] = 1'b1;
        step();
        step();
        b[0] = 8'h81;
        send(0, b[0], "rstmid");
        step();
        check_stream(0, b, 1, 16, 1, "rstmid_after");
    endtask

    task automatic test_random();
        bytes_t b;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        send(0, b[0], "random");
        step();
        fork
            check_stream(0, b, 4, 16, 1, "random");
            for (int i = 1; i < 4; i++) send(0, b[i], "random");
        join
    endtask

    task automatic test_two_stop();
        bytes_t b;
        b[0] = 8'h00;
        send(1, b[0], "two_stop");
        step();
        check_stream(1, b, 1, 16, 2, "two_stop");
    endtask

    task automatic test_default_timing();
        bytes_t b;
        b[0] = 8'hC3;
        send(2, b[0], "default");
        step();
        check_stream(2, b, 1, 5208, 1, "default");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_random();
        test_two_stop();
        test_default_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART 8N1 transmitter: serialises one byte per frame onto TX_LINE, LSB first, with one start bit, eight data bits and one or two stop bits. It is the transmit-side counterpart of the existing UART receiver and uses the same bit timing (50 MHz clock, 9600 baud, 5208 clocks per bit). A one-byte holding register accepts the next byte while the current frame is on the line, so frames can be sent back-to-back with no idle gap.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per bit period (legal range 2..65535).
STOP_BITS, 1, number of stop bits (legal values 1 or 2).

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST_N  input  1  asynchronous active-low reset.
DATA  input  8  byte to transmit; sampled only on the accept edge.
START  input  1  request to send DATA.
READY  output  1  high when the holding register is empty and a START will be accepted.
TX_LINE  output  1  serial line; idles high.
BUSY  output  1  high while a frame (start, data or stop bit) is being driven.
DONE  output  1  one-cycle pulse when a frame's final stop bit completes.

Behaviour:
- Reset (RST_N=0, asynchronous): TX_LINE=1, BUSY=0, READY=1, DONE=0; holding register empty; FSM in IDLE; counters cleared. Reset mid-frame aborts the frame and TX_LINE goes high immediately, without waiting for a clock edge.
- Accept: at a rising edge where START=1 and READY=1, DATA is latched into the holding register and READY is 0 after that edge. START while READY=0 is ignored, with no error. DATA changes after the accept edge do not affect the frame.
- FSM states and transitions:
  - IDLE: TX_LINE=1, BUSY=0. If the holding register is full, the next edge moves the byte into the shift register, empties the holding register (READY=1) and enters START_BIT.
  - START_BIT: TX_LINE=0 for CLKS_PER_BIT cycles, then DATA_BITS.
  - DATA_BITS: TX_LINE = shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. A 3-bit index counts bits 0..7; after bit 7 go to STOP_BIT.
  - STOP_BIT: TX_LINE=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final edge:
    - DONE=1 for exactly one cycle.
    - If the holding register is full: load the shift register, READY=1, go directly to START_BIT.
    - Otherwise go to IDLE.
- Latency: accept at edge N with FSM in IDLE gives TX_LINE=0 from edge N+1.
- Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles exactly.
- Back-to-back: no idle cycles between frames. BUSY stays 1 continuously across back-to-back frames.
- Simultaneous events: a START accepted on the same edge the holding register empties into the shift register is legal. READY is registered, so this reduces to the normal accept rule; the holding register never loses or overwrites an unsent byte.
- BUSY=1 in START_BIT, DATA_BITS and STOP_BIT; 0 only in IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and clears on entering START_BIT.
- All outputs are registered (no combinational path from START to any output).

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START_BIT, DATA_BITS, STOP_BIT).
  - Constant DEFAULT_CLKS_PER_BIT=5208, shared with the receiver.
  - Constants DATA_BITS=8 and IDLE_LEVEL=1'b1.
- Sub-module uart_baud_gen: parameterised bit-period counter with a clear input and a one-cycle bit_end output. It is natural to factor out and reusable by the receiver.

Test Plan:
- Single byte (CLKS_PER_BIT=16, STOP_BITS=1): accept 0x55 -> TX_LINE reads 0,1,0,1,0,1,0,1,0,1 at 16-cycle intervals. Frame is 160 cycles; DONE pulses once; BUSY drops the cycle after.
- Back-to-back: accept 0xA5, then 0x3C as soon as READY=1 -> two contiguous 160-cycle frames, bits 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1. No idle cycle between; two DONE pulses.
- Ignored request: START held with 0xFF while READY=0 and the holding register full with 0x12 -> 0x12 is transmitted; 0xFF is never sent unless re-accepted after READY=1.
- Reset mid-frame: assert RST_N=0 during data bit 3 -> TX_LINE=1, BUSY=0, READY=1, DONE=0 asynchronously. After release, accept 0x81 -> clean full frame.
- STOP_BITS=2: accept 0x00 -> TX_LINE low for 144 cycles, high for 32. Frame is 176 cycles.
- Default timing (CLKS_PER_BIT=5208): accept 0xC3 -> each bit is exactly 5208 cycles; the frame decodes as 0xC3 in the existing receiver.
